// File: rtl/wb_stage_if.sv
// Bundle of execute-side, memory-return and register-file write signals for
// the writeback stage. The slave modport is the stage itself; the master
// modport is whoever drives the execute and memory side and observes the
// register-file write.
interface wb_stage_if;
    // execute-stage handshake and payload
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_rd_i;
    logic [31:0] ex_result_i;
    logic        ex_is_load_i;
    logic [2:0]  ex_funct3_i;

    // memory read return
    logic [31:0] mem_rdata_i;
    logic        mem_rvalid_i;

    // register-file write and status pulses
    logic [4:0]  w_addr_o;
    logic [31:0] din_o;
    logic        retire_o;
    logic        err_o;

    modport slave (
        input  ex_valid_i,
        output ex_ready_o,
        input  ex_rd_i,
        input  ex_result_i,
        input  ex_is_load_i,
        input  ex_funct3_i,
        input  mem_rdata_i,
        input  mem_rvalid_i,
        output w_addr_o,
        output din_o,
        output retire_o,
        output err_o
    );

    modport master (
        output ex_valid_i,
        input  ex_ready_o,
        output ex_rd_i,
        output ex_result_i,
        output ex_is_load_i,
        output ex_funct3_i,
        output mem_rdata_i,
        output mem_rvalid_i,
        input  w_addr_o,
        input  din_o,
        input  retire_o,
        input  err_o
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results in one cycle, and for loads waits for
// the memory return word, extracts/extends the addressed byte or halfword and
// writes it to the register file. A load that never sees mem_rvalid_i within
// LOAD_TIMEOUT cycles, or that has an unsupported funct3, is dropped with an
// err_o pulse.
// Optional build macro WB_MISALIGN_CHECK_EN: when defined, misaligned LH/LHU/LW
// addresses are rejected like an illegal funct3; when undefined the low
// address bits that do not select a lane are simply ignored.
module wb_stage #(
    parameter int LOAD_TIMEOUT = 16  // legal 2..255
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    wb_stage_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Last counter value before a pending load is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    state_e      state_q,  state_d;
    logic [7:0]  cnt_q,    cnt_d;
    logic [4:0]  rd_q,     rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic [4:0]  w_addr_q, w_addr_d;
    logic [31:0] din_q,    din_d;
    logic        retire_q, retire_d;
    logic        err_q,    err_d;

    logic [7:0]  rdata_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic        load_illegal;

    // Split the returned word into byte lanes for offset selection.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rdata_byte[gi] = bus.mem_rdata_i[8*gi +: 8];
        end
    endgenerate

    // Select the addressed lane and apply sign or zero extension.
    always_comb begin
        byte_sel  = rdata_byte[offset_q];
        half_sel  = offset_q[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        load_data = bus.mem_rdata_i;
        case (funct3_q)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   load_data = bus.mem_rdata_i;
            F3_LBU:  load_data = {24'd0, byte_sel};
            F3_LHU:  load_data = {16'd0, half_sel};
            default: load_data = bus.mem_rdata_i;
        endcase
    end

    // Decide whether an incoming load must be rejected instead of waited on.
    always_comb begin
        load_illegal = 1'b0;
        case (bus.ex_funct3_i)
            F3_LB, F3_LBU: load_illegal = 1'b0;
`ifdef WB_MISALIGN_CHECK_EN
            F3_LH, F3_LHU: load_illegal = bus.ex_result_i[0];
            F3_LW:         load_illegal = (bus.ex_result_i[1:0] != 2'b00);
`else
            F3_LH, F3_LHU: load_illegal = 1'b0;
            F3_LW:         load_illegal = 1'b0;
`endif
            default:       load_illegal = 1'b1;
        endcase
    end

    // Next-state and registered-output computation for the IDLE/WAIT machine.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        funct3_d = funct3_q;
        offset_d = offset_q;
        w_addr_d = 5'd0;      // register file writes on any nonzero address
        din_d    = din_q;
        retire_d = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // mem_rvalid_i has no meaning here and is deliberately ignored
                if (bus.ex_valid_i) begin
                    if (!bus.ex_is_load_i) begin
                        w_addr_d = bus.ex_rd_i;
                        din_d    = bus.ex_result_i;
                        retire_d = 1'b1;
                    end else if (load_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        rd_d     = bus.ex_rd_i;
                        funct3_d = bus.ex_funct3_i;
                        offset_d = bus.ex_result_i[1:0];
                        cnt_d    = 8'd0;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // returned data takes priority over an expiring counter
                if (bus.mem_rvalid_i) begin
                    w_addr_d = rd_q;
                    din_d    = load_data;
                    retire_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, captured load fields and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            rd_q     <= 5'd0;
            funct3_q <= 3'd0;
            offset_q <= 2'd0;
            w_addr_q <= 5'd0;
            din_q    <= 32'd0;
            retire_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            funct3_q <= funct3_d;
            offset_q <= offset_d;
            w_addr_q <= w_addr_d;
            din_q    <= din_d;
            retire_q <= retire_d;
            err_q    <= err_d;
        end
    end

    assign bus.ex_ready_o = (state_q == ST_IDLE);
    assign bus.w_addr_o   = w_addr_q;
    assign bus.din_o      = din_q;
    assign bus.retire_o   = retire_q;
    assign bus.err_o      = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage with LOAD_TIMEOUT=16.
module tb_wb_stage;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    wb_stage_if bus ();

    wb_stage #(.LOAD_TIMEOUT(16)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [4:0] wa, input logic [31:0] d,
                             input logic ret, input logic er, input logic rdy);
        check({tag, ".w_addr"}, {27'd0, bus.w_addr_o}, {27'd0, wa});
        check({tag, ".din"}, bus.din_o, d);
        check({tag, ".retire"}, {31'd0, bus.retire_o}, {31'd0, ret});
        check({tag, ".err"}, {31'd0, bus.err_o}, {31'd0, er});
        check({tag, ".ready"}, {31'd0, bus.ex_ready_o}, {31'd0, rdy});
    endtask

    task automatic idle_check(input string tag);
        check({tag, ".w_addr"}, {27'd0, bus.w_addr_o}, 32'd0);
        check({tag, ".retire"}, {31'd0, bus.retire_o}, 32'd0);
        check({tag, ".err"}, {31'd0, bus.err_o}, 32'd0);
    endtask

    task automatic drive(input logic v, input logic ld, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] res);
        bus.ex_valid_i   = v;
        bus.ex_is_load_i = ld;
        bus.ex_funct3_i  = f3;
        bus.ex_rd_i      = rd;
        bus.ex_result_i  = res;
    endtask

    task automatic mem(input logic v, input logic [31:0] d);
        bus.mem_rvalid_i = v;
        bus.mem_rdata_i  = d;
    endtask

    // Issue a load, then return data after 'gap' idle WAIT cycles and check result.
    task automatic load_ok(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] addr, input int gap,
                           input logic [31:0] rdata, input logic [31:0] exp);
        drive(1'b1, 1'b1, f3, rd, addr);
        tick();
        drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0);
        check({tag, ".wait_ready"}, {31'd0, bus.ex_ready_o}, 32'd0);
        for (int i = 0; i < gap; i++) tick();
        mem(1'b1, rdata);
        tick();
        mem(1'b0, 32'd0);
        check_out(tag, rd, exp, 1'b1, 1'b0, 1'b1);
        $display("load %s f3=%0d addr=%h rdata=%h -> din=%h", tag, f3, addr, rdata, bus.din_o);
    endtask

    initial begin
        drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0);
        mem(1'b0, 32'd0);

        // reset state
        tick();
        tick();
        check_out("reset", 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        rst_n_i = 1'b1;
        tick();
        idle_check("post_reset");

        // simple non-load, then write address returns to 0
        drive(1'b1, 1'b0, 3'd0, 5'd5, 32'h1234_5678);
        tick();
        check_out("alu_rd5", 5'd5, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0);
        tick();
        idle_check("alu_rd5_after");
        $display("alu rd=5 result=12345678 retired");

        // back-to-back non-loads
        drive(1'b1, 1'b0, 3'd0, 5'd1, 32'hAAAA_0001);
        tick();
        check_out("b2b_1", 5'd1, 32'hAAAA_0001, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 3'd0, 5'd2, 32'hBBBB_0002);
        tick();
        check_out("b2b_2", 5'd2, 32'hBBBB_0002, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 3'd0, 5'd31, 32'hCCCC_0003);
        tick();
        check_out("b2b_3", 5'd31, 32'hCCCC_0003, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0);
        tick();
        idle_check("b2b_after");
        $display("back-to-back alu x3 retired");

        // rd = 0: retires, never writes
        drive(1'b1, 1'b0, 3'd0, 5'd0, 32'hFFFF_FFFF);
        tick();
        check("rd0.retire", {31'd0, bus.retire_o}, 32'd1);
        check("rd0.w_addr", {27'd0, bus.w_addr_o}, 32'd0);
        drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0);
        tick();
        idle_check("rd0_after");
        $display("alu rd=0 retired without write");

        // rvalid while idle is ignored
        mem(1'b1, 32'hDEAD_BEEF);
        tick();
        mem(1'b0, 32'd0);
        idle_check("idle_rvalid");
        $display("idle rvalid ignored");

        // loads with extraction
        load_ok("lb_off3", 3'd0, 5'd7, 32'h0000_1003, 2, 32'h80FF_0000, 32'hFFFF_FF80);
        tick();
        idle_check("lb_after");
        load_ok("lhu_off2", 3'd5, 5'd9, 32'h0000_2002, 0, 32'hBEEF_1234, 32'h0000_BEEF);
        load_ok("lh_off0", 3'd1, 5'd10, 32'h0000_0000, 1, 32'h1234_8001, 32'hFFFF_8001);
        load_ok("lbu_off1", 3'd4, 5'd11, 32'h0000_0041, 0, 32'h0000_A500, 32'h0000_00A5);
        load_ok("lb_off0_pos", 3'd0, 5'd12, 32'h0000_0000, 0, 32'hFFFF_FF7F, 32'h0000_007F);
        load_ok("lw", 3'd2, 5'd13, 32'h0000_0100, 3, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // timeout: err 16 cycles after WAIT entry
        drive(1'b1, 1'b1, 3'd2, 5'd4, 32'h0000_0200);
        tick();
        drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0);
        for (int k = 1; k < 16; k++) begin
            tick();
            check("to_wait.err", {31'd0, bus.err_o}, 32'd0);
            check("to_wait.w_addr", {27'd0, bus.w_addr_o}, 32'd0);
            check("to_wait.ready", {31'd0, bus.ex_ready_o}, 32'd0);
        end
        tick();
        check("to_fire.err", {31'd0, bus.err_o}, 32'd1);
        check("to_fire.w_addr", {27'd0, bus.w_addr_o}, 32'd0);
        check("to_fire.retire", {31'd0, bus.retire_o}, 32'd0);
        check("to_fire.ready", {31'd0, bus.ex_ready_o}, 32'd1);
        tick();
        idle_check("to_after");
        $display("load timeout -> err pulse");

        // data on the expiring edge wins
        load_ok("expiry_data", 3'd2, 5'd14, 32'h0000_0300, 15, 32'h0BAD_CAFE, 32'h0BAD_CAFE);
        tick();
        idle_check("expiry_after");

        // illegal funct3 loads
        drive(1'b1, 1'b1, 3'd3, 5'd6, 32'h0000_0000);
        tick();
        check_out("ill_f3_3", 5'd0, 32'h0BAD_CAFE, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 3'd7, 5'd6, 32'h0000_0000);
        tick();
        check("ill_f3_7.err", {31'd0, bus.err_o}, 32'd1);
        check("ill_f3_7.w_addr", {27'd0, bus.w_addr_o}, 32'd0);
        drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0);
        tick();
        idle_check("ill_after");
        $display("illegal funct3 loads rejected");

        // misaligned LW
`ifdef WB_MISALIGN_CHECK_EN
        drive(1'b1, 1'b1, 3'd2, 5'd15, 32'h0000_0001);
        tick();
        drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0);
        check("mis_lw.err", {31'd0, bus.err_o}, 32'd1);
        check("mis_lw.ready", {31'd0, bus.ex_ready_o}, 32'd1);
`else
        load_ok("mis_lw", 3'd2, 5'd15, 32'h0000_0001, 0, 32'h1357_9BDF, 32'h1357_9BDF);
`endif

        // reset in WAIT abandons the load
        drive(1'b1, 1'b1, 3'd2, 5'd8, 32'h0000_0400);
        tick();
        drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0);
        check("rst_wait.ready", {31'd0, bus.ex_ready_o}, 32'd0);
        tick();
        rst_n_i = 1'b0;
        #1;
        check_out("rst_mid", 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        rst_n_i = 1'b1;
        mem(1'b1, 32'h5555_AAAA);
        tick();
        mem(1'b0, 32'd0);
        check_out("rst_rvalid", 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        idle_check("rst_after");
        $display("reset mid-WAIT abandoned load");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
